// File: rtl/video_writer_if.sv
// rtl/video_writer_if.sv - byte command stream in, video cell writes and cursor status out
interface video_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        video_write;
  logic [15:0] video_address;
  logic [23:0] video_value;
  logic [23:0] video_mask;
  logic [7:0]  cursor_x;
  logic [7:0]  cursor_y;
  logic        busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, video_write, video_address, video_value, video_mask,
           cursor_x, cursor_y, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, video_write, video_address, video_value, video_mask,
           cursor_x, cursor_y, busy
  );
endinterface

// File: rtl/video_writer.sv
// rtl/video_writer.sv - text-mode writer: printable bytes, cursor/attribute escapes, screen clear
module video_writer #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter logic [15:0] DEFAULT_ATTR = 16'h0F00
) (
  input  logic         clk,
  input  logic         reset,
  video_writer_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTR_HI = 3'd1;
  localparam logic [2:0] S_ATTR_LO = 3'd2;
  localparam logic [2:0] S_POS_ROW = 3'd3;
  localparam logic [2:0] S_POS_COL = 3'd4;
  localparam logic [2:0] S_CLEAR   = 3'd5;

  localparam logic [15:0] COLS_W    = 16'(COLS);
  localparam logic [15:0] LAST_ADDR = 16'(ROWS * COLS - 1);
  localparam logic [7:0]  MAX_COL   = 8'(COLS - 1);
  localparam logic [7:0]  MAX_ROW   = 8'(ROWS - 1);

  logic [2:0]  state;
  logic [15:0] attr;
  logic [7:0]  row_hold;
  logic        accept;
  logic [15:0] cell_addr;

  assign bus.in_ready = (state != S_CLEAR);
  assign bus.busy     = (state == S_CLEAR);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cell_addr    = {8'd0, bus.cursor_y} * COLS_W + {8'd0, bus.cursor_x};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      attr              <= DEFAULT_ATTR;
      row_hold          <= 8'd0;
      bus.cursor_x      <= 8'd0;
      bus.cursor_y      <= 8'd0;
      bus.video_write   <= 1'b0;
      bus.video_address <= 16'd0;
      bus.video_value   <= 24'd0;
      bus.video_mask    <= 24'd0;
    end else begin
      bus.video_write <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (bus.in_data >= 8'h20) begin
            bus.video_write   <= 1'b1;
            bus.video_address <= cell_addr;
            bus.video_value   <= {attr, bus.in_data};
            bus.video_mask    <= 24'hFFFFFF;
            if (bus.cursor_x == MAX_COL) begin
              bus.cursor_x <= 8'd0;
              bus.cursor_y <= (bus.cursor_y == MAX_ROW) ? 8'd0 : bus.cursor_y + 8'd1;
            end else begin
              bus.cursor_x <= bus.cursor_x + 8'd1;
            end
          end else begin
            case (bus.in_data)
              8'h0D: bus.cursor_x <= 8'd0;
              8'h0A: bus.cursor_y <= (bus.cursor_y == MAX_ROW) ? 8'd0 : bus.cursor_y + 8'd1;
              8'h08: begin
                if (bus.cursor_x != 8'd0) begin
                  bus.cursor_x <= bus.cursor_x - 8'd1;
                end else if (bus.cursor_y != 8'd0) begin
                  bus.cursor_x <= MAX_COL;
                  bus.cursor_y <= bus.cursor_y - 8'd1;
                end
              end
              8'h1B: state <= S_ATTR_HI;
              8'h1F: state <= S_POS_ROW;
              8'h0C: begin
                // The first clear write goes out with the state change so that
                // busy covers exactly the cycles on which writes are presented.
                state             <= S_CLEAR;
                bus.video_write   <= 1'b1;
                bus.video_address <= 16'd0;
                bus.video_value   <= {attr, 8'h20};
                bus.video_mask    <= 24'hFFFFFF;
              end
              default: ;
            endcase
          end
        end
        S_ATTR_HI: if (accept) begin
          attr[15:8] <= bus.in_data;
          state      <= S_ATTR_LO;
        end
        S_ATTR_LO: if (accept) begin
          attr[7:0] <= bus.in_data;
          state     <= S_IDLE;
        end
        S_POS_ROW: if (accept) begin
          row_hold <= (bus.in_data > MAX_ROW) ? MAX_ROW : bus.in_data;
          state    <= S_POS_COL;
        end
        S_POS_COL: if (accept) begin
          bus.cursor_x <= (bus.in_data > MAX_COL) ? MAX_COL : bus.in_data;
          bus.cursor_y <= row_hold;
          state        <= S_IDLE;
        end
        S_CLEAR: begin
          if (bus.video_address == LAST_ADDR) begin
            state        <= S_IDLE;
            bus.cursor_x <= 8'd0;
            bus.cursor_y <= 8'd0;
          end else begin
            bus.video_write   <= 1'b1;
            bus.video_address <= bus.video_address + 16'd1;
            bus.video_value   <= {attr, 8'h20};
            bus.video_mask    <= 24'hFFFFFF;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_writer.sv
// tb/tb_video_writer.sv - directed self-checking bench for video_writer
module tb_video_writer;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  video_writer_if vif ();

  video_writer #(.COLS(80), .ROWS(30), .DEFAULT_ATTR(16'h0F00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for a single cycle; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    vif.in_data  = b;
    vif.in_valid = 1'b1;
    @(negedge clk);
    vif.in_valid = 1'b0;
  endtask

  task automatic check_cursor(input string tag, input logic [7:0] x, input logic [7:0] y);
    check({tag, "_x"}, {24'd0, vif.cursor_x}, {24'd0, x});
    check({tag, "_y"}, {24'd0, vif.cursor_y}, {24'd0, y});
  endtask

  initial begin
    int bad;
    tests_run    = 0;
    tests_failed = 0;
    vif.in_data  = 8'h00;
    vif.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    check("rst_write", {31'd0, vif.video_write}, 32'd0);
    check("rst_addr", {16'd0, vif.video_address}, 32'd0);
    check("rst_value", {8'd0, vif.video_value}, 32'd0);
    check("rst_mask", {8'd0, vif.video_mask}, 32'd0);
    check("rst_busy", {31'd0, vif.busy}, 32'd0);
    check("rst_ready", {31'd0, vif.in_ready}, 32'd1);
    check_cursor("rst_cur", 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    send(8'h41);
    check("A_write", {31'd0, vif.video_write}, 32'd1);
    check("A_addr", {16'd0, vif.video_address}, 32'd0);
    check("A_value", {8'd0, vif.video_value}, 32'h0F0041);
    check("A_mask", {8'd0, vif.video_mask}, 32'hFFFFFF);
    check_cursor("A_cur", 8'd1, 8'd0);
    @(negedge clk);
    check("A_one_shot", {31'd0, vif.video_write}, 32'd0);

    send(8'h01);
    check("ign_write", {31'd0, vif.video_write}, 32'd0);
    check_cursor("ign_cur", 8'd1, 8'd0);

    send(8'h1F);
    check("pos_cmd_write", {31'd0, vif.video_write}, 32'd0);
    send(8'd5);
    check_cursor("pos_row_only", 8'd1, 8'd0);
    send(8'd79);
    check_cursor("pos_5_79", 8'd79, 8'd5);
    send(8'h42);
    check("B_addr", {16'd0, vif.video_address}, 32'd479);
    check("B_value", {8'd0, vif.video_value}, 32'h0F0042);
    check_cursor("B_wrap", 8'd0, 8'd6);

    send(8'h1F);
    send(8'd40);
    send(8'd200);
    check_cursor("pos_clamp", 8'd79, 8'd29);
    send(8'h43);
    check("C_write", {31'd0, vif.video_write}, 32'd1);
    check("C_addr", {16'd0, vif.video_address}, 32'd2399);
    check_cursor("C_wrap", 8'd0, 8'd0);

    send(8'h1B);
    check("esc_write", {31'd0, vif.video_write}, 32'd0);
    send(8'h12);
    check("attr_hi_write", {31'd0, vif.video_write}, 32'd0);
    send(8'h34);
    check("attr_lo_write", {31'd0, vif.video_write}, 32'd0);
    send(8'h44);
    check("D_value", {8'd0, vif.video_value}, 32'h123444);
    check("D_addr", {16'd0, vif.video_address}, 32'd0);

    send(8'h0C);
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      if (vif.video_write !== 1'b1 || vif.video_address !== 16'(i) ||
          vif.video_value !== 24'h123420 || vif.video_mask !== 24'hFFFFFF ||
          vif.busy !== 1'b1 || vif.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    check("clear_seq_bad_cycles", bad, 32'd0);
    check("clear_done_write", {31'd0, vif.video_write}, 32'd0);
    check("clear_done_busy", {31'd0, vif.busy}, 32'd0);
    check("clear_done_ready", {31'd0, vif.in_ready}, 32'd1);
    check_cursor("clear_done_cur", 8'd0, 8'd0);

    send(8'h0C);
    for (int i = 0; i < 100; i++) @(negedge clk);
    check("clr2_at100_addr", {16'd0, vif.video_address}, 32'd100);
    reset = 1'b1;
    #1;
    check("clr2_rst_write", {31'd0, vif.video_write}, 32'd0);
    check("clr2_rst_addr", {16'd0, vif.video_address}, 32'd0);
    check("clr2_rst_busy", {31'd0, vif.busy}, 32'd0);
    check("clr2_rst_ready", {31'd0, vif.in_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vif.video_write !== 1'b0 || vif.video_value !== 24'd0) bad++;
    end
    check("clr2_rst_hold", bad, 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vif.video_write !== 1'b0 || vif.busy !== 1'b0) bad++;
    end
    check("clr2_no_resume", bad, 32'd0);

    send(8'h0A);
    check_cursor("lf_cur", 8'd0, 8'd1);
    send(8'h08);
    check("bs_write", {31'd0, vif.video_write}, 32'd0);
    check_cursor("bs_row_back", 8'd79, 8'd0);
    send(8'h0D);
    check_cursor("cr_cur", 8'd0, 8'd0);
    send(8'h08);
    check_cursor("bs_origin", 8'd0, 8'd0);

    vif.in_data  = 8'h78;
    vif.in_valid = 1'b1;
    @(negedge clk);
    check("x_write", {31'd0, vif.video_write}, 32'd1);
    check("x_addr", {16'd0, vif.video_address}, 32'd0);
    check("x_value", {8'd0, vif.video_value}, 32'h0F0078);
    vif.in_data = 8'h79;
    @(negedge clk);
    check("y_write", {31'd0, vif.video_write}, 32'd1);
    check("y_addr", {16'd0, vif.video_address}, 32'd1);
    vif.in_data = 8'h7A;
    @(negedge clk);
    vif.in_valid = 1'b0;
    check("z_write", {31'd0, vif.video_write}, 32'd1);
    check("z_addr", {16'd0, vif.video_address}, 32'd2);
    check("z_value", {8'd0, vif.video_value}, 32'h0F007A);
    check_cursor("xyz_cur", 8'd3, 8'd0);
    @(negedge clk);
    check("xyz_idle", {31'd0, vif.video_write}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
